// File: rtl/mouse_packet_tracker.sv
// rtl/mouse_packet_tracker.sv - PS/2 mouse packet decoder and X/Y/Z position tracker; define MOUSE_WHEEL_EN for 4-byte wheel packets
module mouse_packet_tracker #(
  parameter int X_MAX       = 159,
  parameter int Y_MAX       = 119,
  parameter int X_INIT      = 80,
  parameter int Y_INIT      = 60,
  parameter int TIMEOUT_CYC = 2_000_000
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [7:0] BYTE_IN,
  input  logic       BYTE_VALID,
  input  logic       BYTE_ERROR,
  input  logic       STREAM_EN,
  output logic [3:0] MOUSE_STATUS,
  output logic [7:0] MOUSE_X,
  output logic [7:0] MOUSE_Y,
  output logic [7:0] MOUSE_Z,
  output logic       SEND_INTERRUPT,
  output logic       PKT_ERROR
);

  localparam int                CNT_W    = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic signed [9:0] X_MAX_S  = 10'(X_MAX);
  localparam logic signed [9:0] Y_MAX_S  = 10'(Y_MAX);

`ifdef MOUSE_WHEEL_EN
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_B1     = 3'd1,
    S_B2     = 3'd2,
    S_B3     = 3'd3,
    S_UPDATE = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_B1     = 3'd1,
    S_B2     = 3'd2,
    S_UPDATE = 3'd4
  } state_t;
`endif

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] cnt_q;

  // Header byte fields kept from byte0 (bit 3 is always 1 and not stored)
  logic       ovf_y_q;
  logic       ovf_x_q;
  logic       sgn_y_q;
  logic       sgn_x_q;
  logic [2:0] btn_q;
  logic [7:0] b1_q;
  logic [7:0] dy_byte;

  logic take_b0;
  logic take_b1;
  logic take_b2;
  logic take_last;
  logic abort;
  logic in_pkt;
  logic timeout_hit;
  logic byte_taken;

  logic signed [9:0] dx;
  logic signed [9:0] dy;
  logic signed [9:0] x_sum;
  logic signed [9:0] y_sum;
  logic [7:0]        x_new;
  logic [7:0]        y_new;

  assign in_pkt      = (state_q != S_IDLE) && (state_q != S_UPDATE);
  assign timeout_hit = in_pkt && (cnt_q == CNT_LAST);
  assign byte_taken  = take_b0 | take_b1 | take_b2 | take_last;

  // State register
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state and byte-capture decode; errors abort any collecting state, UPDATE re-evaluates bytes as byte0
  always_comb begin
    state_d   = state_q;
    take_b0   = 1'b0;
    take_b1   = 1'b0;
    take_b2   = 1'b0;
    take_last = 1'b0;
    abort     = 1'b0;
    if (!STREAM_EN) begin
      state_d = S_IDLE;
    end else if (BYTE_ERROR && (state_q != S_UPDATE)) begin
      abort = 1'b1;
    end else begin
      case (state_q)
        S_IDLE, S_UPDATE: begin
          state_d = S_IDLE;
          if (BYTE_VALID && BYTE_IN[3]) begin
            take_b0 = 1'b1;
            state_d = S_B1;
          end
        end
        S_B1: begin
          if (BYTE_VALID) begin
            take_b1 = 1'b1;
            state_d = S_B2;
          end else if (timeout_hit) begin
            abort = 1'b1;
          end
        end
        S_B2: begin
          if (BYTE_VALID) begin
`ifdef MOUSE_WHEEL_EN
            take_b2 = 1'b1;
            state_d = S_B3;
`else
            take_last = 1'b1;
            state_d   = S_UPDATE;
`endif
          end else if (timeout_hit) begin
            abort = 1'b1;
          end
        end
`ifdef MOUSE_WHEEL_EN
        S_B3: begin
          if (BYTE_VALID) begin
            take_last = 1'b1;
            state_d   = S_UPDATE;
          end else if (timeout_hit) begin
            abort = 1'b1;
          end
        end
`endif
        default: state_d = S_IDLE;
      endcase
    end
    if (abort) state_d = S_IDLE;
  end

  // Inter-byte timeout counter, running only while a packet is partially collected
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET)                                        cnt_q <= '0;
    else if (!STREAM_EN || !in_pkt || byte_taken || abort) cnt_q <= '0;
    else                                              cnt_q <= cnt_q + CNT_W'(1);
  end

  // Packet byte capture
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      ovf_y_q <= 1'b0;
      ovf_x_q <= 1'b0;
      sgn_y_q <= 1'b0;
      sgn_x_q <= 1'b0;
      btn_q   <= 3'd0;
      b1_q    <= 8'd0;
    end else begin
      if (take_b0) begin
        ovf_y_q <= BYTE_IN[7];
        ovf_x_q <= BYTE_IN[6];
        sgn_y_q <= BYTE_IN[5];
        sgn_x_q <= BYTE_IN[4];
        btn_q   <= BYTE_IN[2:0];
      end
      if (take_b1) b1_q <= BYTE_IN;
    end
  end

`ifdef MOUSE_WHEEL_EN
  logic [7:0] b2_q;

  // Y movement byte is held until the wheel byte completes the packet
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET)        b2_q <= 8'd0;
    else if (take_b2) b2_q <= BYTE_IN;
  end

  assign dy_byte = b2_q;
`else
  assign dy_byte = BYTE_IN;
`endif

  // Signed 10-bit movement with overflow squash and clamping to the screen
  always_comb begin
    dx    = ovf_x_q ? 10'sd0 : $signed({sgn_x_q, sgn_x_q, b1_q});
    dy    = ovf_y_q ? 10'sd0 : $signed({sgn_y_q, sgn_y_q, dy_byte});
    x_sum = $signed({2'b00, MOUSE_X}) + dx;
    y_sum = $signed({2'b00, MOUSE_Y}) - dy;
    x_new = x_sum[7:0];
    y_new = y_sum[7:0];
    if (x_sum < 10'sd0)        x_new = 8'd0;
    else if (x_sum > X_MAX_S)  x_new = 8'(X_MAX);
    if (y_sum < 10'sd0)        y_new = 8'd0;
    else if (y_sum > Y_MAX_S)  y_new = 8'(Y_MAX);
  end

  // Published position/status and one-cycle event pulses, registered as the last byte lands
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      MOUSE_X        <= 8'(X_INIT);
      MOUSE_Y        <= 8'(Y_INIT);
      MOUSE_STATUS   <= 4'd0;
      SEND_INTERRUPT <= 1'b0;
      PKT_ERROR      <= 1'b0;
    end else begin
      SEND_INTERRUPT <= take_last;
      PKT_ERROR      <= abort;
      if (take_last) begin
        MOUSE_X      <= x_new;
        MOUSE_Y      <= y_new;
        MOUSE_STATUS <= {ovf_y_q | ovf_x_q, btn_q};
      end
    end
  end

`ifdef MOUSE_WHEEL_EN
  // Wheel count wraps modulo 256 with the sign-extended low nibble of byte3
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET)          MOUSE_Z <= 8'd0;
    else if (take_last) MOUSE_Z <= MOUSE_Z + {{4{BYTE_IN[3]}}, BYTE_IN[3:0]};
  end
`else
  assign MOUSE_Z = 8'd0;
`endif

endmodule
